// File: rtl/alu_fifo_if.sv
// Bundle between the reservation station / instruction queue and the ALU
// result FIFO: global ready, phase control, issue port and IQ writeback port.
interface alu_fifo_if #(
  parameter int XLEN      = 32,
  parameter int IQ_ADDR_W = 4,
  parameter int CALC_W    = 5
);
  logic                 rdy;
  logic                 chip_enable;
  logic                 update_stat;
  logic                 clear_flag_in;
  logic [31:0]          clear_pc_in;
  logic                 rs_full_out;
  logic                 rs_calc_enable_in;
  logic [CALC_W-1:0]    rs_calc_code_in;
  logic [XLEN-1:0]      rs_lhs_in;
  logic [XLEN-1:0]      rs_rhs_in;
  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in;
  logic                 iq_write_enable_out;
  logic [IQ_ADDR_W-1:0] iq_write_idx_out;
  logic                 iq_write_result_enable_out;
  logic [XLEN-1:0]      iq_write_result_out;
  logic                 iq_write_need_cdb_enable_out;
  logic                 iq_write_need_cdb_out;
  logic                 iq_write_ready_enable_out;
  logic                 iq_write_ready_out;

  modport master (
    output rdy, update_stat, clear_flag_in, clear_pc_in, rs_calc_enable_in,
           rs_calc_code_in, rs_lhs_in, rs_rhs_in, rs_pos_in_iq_in,
    input  chip_enable, rs_full_out, iq_write_enable_out, iq_write_idx_out,
           iq_write_result_enable_out, iq_write_result_out,
           iq_write_need_cdb_enable_out, iq_write_need_cdb_out,
           iq_write_ready_enable_out, iq_write_ready_out
  );

  modport slave (
    input  rdy, update_stat, clear_flag_in, clear_pc_in, rs_calc_enable_in,
           rs_calc_code_in, rs_lhs_in, rs_rhs_in, rs_pos_in_iq_in,
    output chip_enable, rs_full_out, iq_write_enable_out, iq_write_idx_out,
           iq_write_result_enable_out, iq_write_result_out,
           iq_write_need_cdb_enable_out, iq_write_need_cdb_out,
           iq_write_ready_enable_out, iq_write_ready_out
  );
endinterface

// File: rtl/alu_fifo_unit.sv
// Single-cycle integer ALU whose results queue in a DEPTH-entry FIFO and drain
// to the instruction queue one per pop phase, in issue order, with flush.
module alu_fifo_unit #(
  parameter int XLEN      = 32,
  parameter int IQ_ADDR_W = 4,
  parameter int DEPTH     = 2,
  parameter int CALC_W    = 5
) (
  input logic       clk,
  input logic       rst,
  alu_fifo_if.slave bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [XLEN-1:0] flag(input logic c);
    return {{(XLEN-1){1'b0}}, c};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] alu_calc(input logic [CALC_W-1:0] code,
                                               input logic [XLEN-1:0] lhs,
                                               input logic [XLEN-1:0] rhs);
    logic signed [XLEN-1:0] slhs;
    logic signed [XLEN-1:0] srhs;
    logic [SH_W-1:0]        sh;
    logic [XLEN-1:0]        res;
    slhs = $signed(lhs);
    srhs = $signed(rhs);
    sh   = rhs[SH_W-1:0];
    case (code)
      CALC_W'(0):  res = lhs + rhs;
      CALC_W'(1):  res = lhs - rhs;
      CALC_W'(2):  res = lhs << sh;
      CALC_W'(3):  res = flag(slhs < srhs);
      CALC_W'(4):  res = flag(lhs < rhs);
      CALC_W'(5):  res = lhs ^ rhs;
      CALC_W'(6):  res = lhs >> sh;
      CALC_W'(7):  res = XLEN'(slhs >>> sh);
      CALC_W'(8):  res = lhs | rhs;
      CALC_W'(9):  res = lhs & rhs;
      CALC_W'(10): res = flag(lhs == rhs);
      CALC_W'(11): res = flag(lhs != rhs);
      CALC_W'(12): res = flag(slhs < srhs);
      CALC_W'(13): res = flag(slhs >= srhs);
      CALC_W'(14): res = flag(lhs < rhs);
      CALC_W'(15): res = flag(lhs >= rhs);
      CALC_W'(16): res = rhs;
      CALC_W'(17): res = lhs & ~rhs;
      default:     res = '0;
    endcase
    return res;
  endfunction

  logic [XLEN-1:0]      res_mem_p1 [DEPTH];
  logic [IQ_ADDR_W-1:0] pos_mem_p1 [DEPTH];
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [XLEN-1:0]      alu_res_p0;
  logic                 vld_p0;
  logic                 pop_p0;
  logic                 unused_pc;

  assign unused_pc       = ^bus.clear_pc_in;
  assign bus.rs_full_out = (count == FULL_CNT);

  // Stage p0: compute on issue; a full FIFO or a flush drops the op.
  assign alu_res_p0 = alu_calc(bus.rs_calc_code_in, bus.rs_lhs_in, bus.rs_rhs_in);
  assign vld_p0 = bus.chip_enable && bus.update_stat && !bus.clear_flag_in &&
                  bus.rs_calc_enable_in && !bus.rs_full_out;
  assign pop_p0 = bus.chip_enable && !bus.update_stat && !bus.clear_flag_in &&
                  (count != '0);

  // Stage p1: FIFO storage, written at tail.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      res_mem_p1[tail] <= alu_res_p0;
      pos_mem_p1[tail] <= bus.rs_pos_in_iq_in;
    end
  end

  // Stage p2: FIFO control and IQ writeback registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.chip_enable                  <= 1'b0;
      count                            <= '0;
      head                             <= '0;
      tail                             <= '0;
      bus.iq_write_enable_out          <= 1'b0;
      bus.iq_write_idx_out             <= '0;
      bus.iq_write_result_enable_out   <= 1'b0;
      bus.iq_write_result_out          <= '0;
      bus.iq_write_need_cdb_enable_out <= 1'b0;
      bus.iq_write_need_cdb_out        <= 1'b0;
      bus.iq_write_ready_enable_out    <= 1'b0;
      bus.iq_write_ready_out           <= 1'b0;
    end else begin
      bus.chip_enable <= bus.rdy;
      if (!bus.chip_enable) begin
        bus.iq_write_enable_out <= 1'b0;
      end else if (bus.clear_flag_in) begin
        count                   <= '0;
        head                    <= '0;
        tail                    <= '0;
        bus.iq_write_enable_out <= 1'b0;
      end else if (bus.update_stat) begin
        if (vld_p0) begin
          tail  <= ptr_inc(tail);
          count <= count + 1'b1;
        end
      end else begin
        bus.iq_write_enable_out <= 1'b0;
        if (pop_p0) begin
          bus.iq_write_enable_out          <= 1'b1;
          bus.iq_write_idx_out             <= pos_mem_p1[head];
          bus.iq_write_result_enable_out   <= 1'b1;
          bus.iq_write_result_out          <= res_mem_p1[head];
          bus.iq_write_need_cdb_enable_out <= 1'b1;
          bus.iq_write_need_cdb_out        <= 1'b1;
          bus.iq_write_ready_enable_out    <= 1'b1;
          bus.iq_write_ready_out           <= 1'b1;
          head                             <= ptr_inc(head);
          count                            <= count - 1'b1;
        end
      end
    end
  end

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst)
    (bus.chip_enable && bus.update_stat && !bus.clear_flag_in && bus.rs_calc_enable_in)
      |-> !bus.rs_full_out)
    else $warning("alu_fifo_unit: issue while full was dropped");
endmodule

// File: tb/tb_alu_fifo_unit.sv
// Directed bench for alu_fifo_unit: expected writebacks are queued at issue
// and popped when the unit should write back to the instruction queue.
module tb_alu_fifo_unit;
  localparam int XLEN = 32;
  localparam int IQW  = 4;
  localparam int DEPTH = 2;
  localparam int CW   = 5;

  typedef struct {
    logic [IQW-1:0]  idx;
    logic [XLEN-1:0] res;
  } ent_t;

  logic clk;
  logic rst;
  ent_t sbq[$];
  int   n_chk;
  int   n_fail;
  logic ce_m;
  logic e_we;
  logic e_en;
  logic [IQW-1:0]  e_idx;
  logic [XLEN-1:0] e_res;

  alu_fifo_if #(.XLEN(XLEN), .IQ_ADDR_W(IQW), .CALC_W(CW)) bus ();

  alu_fifo_unit #(.XLEN(XLEN), .IQ_ADDR_W(IQW), .DEPTH(DEPTH), .CALC_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic us, input logic iss, input logic [CW-1:0] code,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [IQW-1:0] pos, input logic [XLEN-1:0] exp_res,
                      input logic clr);
    ent_t e;
    bus.update_stat       = us;
    bus.rs_calc_enable_in = iss;
    bus.rs_calc_code_in   = code;
    bus.rs_lhs_in         = a;
    bus.rs_rhs_in         = b;
    bus.rs_pos_in_iq_in   = pos;
    bus.clear_flag_in     = clr;
    @(posedge clk);
    if (!rst) begin
      ce_m = 1'b0; sbq.delete(); e_we = 1'b0; e_en = 1'b0; e_idx = '0; e_res = '0;
    end else begin
      if (!ce_m) begin
        e_we = 1'b0;
      end else if (clr) begin
        sbq.delete(); e_we = 1'b0;
      end else if (us) begin
        if (iss && sbq.size() < DEPTH) sbq.push_back('{pos, exp_res});
      end else begin
        e_we = 1'b0;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          e_we = 1'b1; e_en = 1'b1; e_idx = e.idx; e_res = e.res;
        end
      end
      ce_m = bus.rdy;
    end
    #1;
    chk("chip_enable", bus.chip_enable, ce_m);
    chk("rs_full", bus.rs_full_out, sbq.size() == DEPTH);
    chk("we", bus.iq_write_enable_out, e_we);
    chk("idx", bus.iq_write_idx_out, e_idx);
    chk("result", bus.iq_write_result_out, e_res);
    chk("result_en", bus.iq_write_result_enable_out, e_en);
    chk("need_cdb_en", bus.iq_write_need_cdb_enable_out, e_en);
    chk("need_cdb", bus.iq_write_need_cdb_out, e_en);
    chk("ready_en", bus.iq_write_ready_enable_out, e_en);
    chk("ready", bus.iq_write_ready_out, e_en);
  endtask

  task automatic push(input logic [CW-1:0] code, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [IQW-1:0] pos,
                      input logic [XLEN-1:0] exp_res);
    step(1'b1, 1'b1, code, a, b, pos, exp_res, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic idle_push();
    step(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ce_m = 1'b0; e_we = 1'b0; e_en = 1'b0; e_idx = '0; e_res = '0;
    rst = 1'b0;
    bus.rdy = 1'b0; bus.clear_pc_in = '0; bus.update_stat = 1'b0;
    bus.clear_flag_in = 1'b0; bus.rs_calc_enable_in = 1'b0; bus.rs_calc_code_in = '0;
    bus.rs_lhs_in = '0; bus.rs_rhs_in = '0; bus.rs_pos_in_iq_in = '0;

    // Reset, then enable.
    idle_push(); pop();
    rst = 1'b1; bus.rdy = 1'b1;
    idle_push();

    // Single add, strobe held through push phase, low on next pop.
    push(5'd0, 32'd5, 32'd7, 4'd3, 32'd12);
    pop(); idle_push(); pop();

    // Fill: third issue dropped, drain in order.
    push(5'd1, 32'd10, 32'd3, 4'd1, 32'd7);
    push(5'd5, 32'h0F0, 32'h0FF, 4'd2, 32'h00F);
    push(5'd8, 32'h1, 32'h2, 4'd4, 32'h3);
    pop(); pop(); pop();

    // Shift amount masking and arithmetic shift.
    push(5'd2, 32'd1, 32'd33, 4'd6, 32'd2);
    push(5'd7, 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000);
    pop(); pop();
    push(5'd6, 32'h8000_0000, 32'd4, 4'd8, 32'h0800_0000);
    pop();

    // Compares and unknown opcode.
    push(5'd3, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd1);
    push(5'd4, 32'hFFFF_FFFF, 32'd1, 4'd10, 32'd0);
    pop(); pop();
    push(5'd15, 32'd1, 32'd1, 4'd11, 32'd1);
    push(5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 4'd12, 32'd0);
    pop(); pop();

    // Flush in pop phase with two queued, then flush dropping an issue.
    push(5'd0, 32'd1, 32'd2, 4'd13, 32'd3);
    push(5'd0, 32'd3, 32'd4, 4'd14, 32'd7);
    step(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b1);
    pop(); idle_push(); pop();
    step(1'b1, 1'b1, 5'd0, 32'd1, 32'd1, 4'd15, 32'd2, 1'b1);
    pop();

    // rdy dropped for three cycles with one entry queued.
    push(5'd9, 32'h0C, 32'h0A, 4'd5, 32'h08);
    bus.rdy = 1'b0;
    idle_push(); pop(); pop(); idle_push();
    bus.rdy = 1'b1;
    pop(); pop(); pop();

    // Reset mid-queue.
    push(5'd16, 32'd0, 32'h1234_5000, 4'd7, 32'h1234_5000);
    push(5'd17, 32'hFF, 32'h0F, 4'd8, 32'hF0);
    pop();
    rst = 1'b0;
    idle_push();
    rst = 1'b1;
    idle_push(); idle_push(); pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
